// File: rtl/decode_imm_ctrl_if.sv
// Fetch-to-execute bundle for the immediate decode stage.
// The slave view belongs to the decoder; the master view drives it.
interface decode_imm_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             instr_valid_i;
  logic [31:0]      instr_rdata_i;
  logic [31:0]      instr_pc_i;
  logic             instr_ready_o;
  logic             imm_valid_o;
  logic             imm_ready_i;
  logic [31:0]      imm_o;
  logic [2:0]       imm_type_o;
  logic [31:0]      pc_o;
  logic             illegal_o;
  logic [31:0]      err_pc_o;
  logic             err_ack_i;
  logic             flush_i;
  logic [CNT_W-1:0] dec_cnt_o;

  modport slave (
    input  instr_valid_i, instr_rdata_i, instr_pc_i,
    input  imm_ready_i, err_ack_i, flush_i,
    output instr_ready_o, imm_valid_o, imm_o, imm_type_o,
    output pc_o, illegal_o, err_pc_o, dec_cnt_o
  );

  modport master (
    output instr_valid_i, instr_rdata_i, instr_pc_i,
    output imm_ready_i, err_ack_i, flush_i,
    input  instr_ready_o, imm_valid_o, imm_o, imm_type_o,
    input  pc_o, illegal_o, err_pc_o, dec_cnt_o
  );
endinterface

// File: rtl/decode_imm_ctrl.sv
// Immediate decode stage: one-entry skid holding the decoded
// immediate, with an illegal-opcode trap state and handshake counter.
module decode_imm_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  decode_imm_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ERR   = 2'd2
  } state_e;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
  localparam logic [2:0] T_ZIMM = 3'd6;

  state_e           state_q, state_d;
  logic [31:0]      imm_q, pc_q, err_pc_q;
  logic [2:0]       type_q;
  logic [CNT_W-1:0] cnt_q;

  logic [31:0] ins;
  logic [31:0] dec_imm;
  logic [2:0]  dec_type;
  logic        dec_ill;
  logic        sgn;
  logic        accept;
  logic        hs;

  assign ins = bus.instr_rdata_i;
  assign sgn = ins[31];

  always_comb begin
    dec_type = T_NONE;
    dec_ill  = 1'b0;
    case (ins[6:0])
      7'b0010011,
      7'b0000011,
      7'b1100111,
      7'b0001111: dec_type = T_I;
      7'b0100011: dec_type = T_S;
      7'b1100011: dec_type = T_B;
      7'b0110111,
      7'b0010111: dec_type = T_U;
      7'b1101111: dec_type = T_J;
      7'b0110011: dec_type = T_NONE;
      7'b1110011: begin
        case (ins[14:12])
          3'b000:  dec_type = T_NONE;
          3'b001,
          3'b010,
          3'b011:  dec_type = T_I;
          3'b100:  dec_ill  = 1'b1;
          default: dec_type = T_ZIMM;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    dec_imm = 32'b0;
    unique case (1'b1)
      dec_type == T_I:
        dec_imm = {{20{sgn}}, ins[31:20]};
      dec_type == T_S:
        dec_imm = {{20{sgn}}, ins[31:25], ins[11:7]};
      dec_type == T_B:
        dec_imm = {{19{sgn}}, ins[31], ins[7],
                   ins[30:25], ins[11:8], 1'b0};
      dec_type == T_U:
        dec_imm = {ins[31:12], 12'b0};
      dec_type == T_J:
        dec_imm = {{12{sgn}}, ins[19:12], ins[20],
                   ins[30:21], 1'b0};
      dec_type == T_ZIMM:
        dec_imm = {27'b0, ins[19:15]};
      default: dec_imm = 32'b0;
    endcase
  end

  assign accept = bus.instr_valid_i && bus.instr_ready_o
                  && !bus.flush_i;
  assign hs     = bus.imm_valid_o && bus.imm_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) state_d = dec_ill ? ERR : VALID;
        end
        VALID: begin
          if (accept)               state_d = dec_ill ? ERR : VALID;
          else if (bus.imm_ready_i) state_d = IDLE;
        end
        ERR: begin
          if (bus.err_ack_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.instr_ready_o = 1'b0;
    bus.imm_valid_o   = 1'b0;
    bus.illegal_o     = 1'b0;
    unique case (state_q)
      IDLE:  bus.instr_ready_o = 1'b1;
      VALID: begin
        bus.instr_ready_o = bus.imm_ready_i;
        bus.imm_valid_o   = 1'b1;
      end
      ERR:   bus.illegal_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      imm_q    <= '0;
      type_q   <= T_NONE;
      pc_q     <= '0;
      err_pc_q <= '0;
    end else if (accept) begin
      if (dec_ill) begin
        err_pc_q <= bus.instr_pc_i;
      end else begin
        imm_q  <= dec_imm;
        type_q <= dec_type;
        pc_q   <= bus.instr_pc_i;
      end
    end
  end

  // Counts even in a flush cycle: the consumer already took the result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)  cnt_q <= '0;
    else if (hs)  cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.imm_o      = imm_q;
  assign bus.imm_type_o = type_q;
  assign bus.pc_o       = pc_q;
  assign bus.err_pc_o   = err_pc_q;
  assign bus.dec_cnt_o  = cnt_q;

endmodule

// File: tb/tb_decode_imm_ctrl.sv
// Randomised and directed bench for decode_imm_ctrl against a
// transaction-level reference model.
module tb_decode_imm_ctrl;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  decode_imm_ctrl_if #(.CNT_W(CNT_W)) bus ();

  decode_imm_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  bit          m_held, m_err;
  logic [31:0] m_imm, m_pc, m_epc;
  logic [2:0]  m_type;
  int          m_cnt;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int sx(int v, int bits);
    if (v >= (1 << (bits - 1))) return v - (1 << bits);
    return v;
  endfunction

  // {illegal, type, imm}
  function automatic logic [35:0] ref_dec(logic [31:0] w);
    int t;
    bit ill;
    int f3;
    int v;
    t   = 0;
    ill = 0;
    f3  = int'(w[14:12]);
    case (w[6:0])
      7'h13, 7'h03, 7'h67, 7'h0F: t = 1;
      7'h23:        t = 2;
      7'h63:        t = 3;
      7'h37, 7'h17: t = 4;
      7'h6F:        t = 5;
      7'h33:        t = 0;
      7'h73: begin
        if (f3 == 0)      t = 0;
        else if (f3 < 4)  t = 1;
        else if (f3 == 4) ill = 1;
        else              t = 6;
      end
      default: ill = 1;
    endcase
    case (t)
      1: v = sx(int'(w[31:20]), 12);
      2: v = sx(int'(w[31:25]) * 32 + int'(w[11:7]), 12);
      3: v = sx(int'(w[31]) * 4096 + int'(w[7]) * 2048
               + int'(w[30:25]) * 32 + int'(w[11:8]) * 2, 13);
      4: v = int'(w & 32'hFFFF_F000);
      5: v = sx(int'(w[31]) * 1048576 + int'(w[19:12]) * 4096
               + int'(w[20]) * 2048 + int'(w[30:21]) * 2, 21);
      6: v = int'(w[19:15]);
      default: v = 0;
    endcase
    if (ill) v = 0;
    return {ill, 3'(t), 32'(v)};
  endfunction

  task automatic drive(bit v, logic [31:0] w, logic [31:0] pc,
                       bit rdy, bit fl, bit ack);
    bus.instr_valid_i = v;
    bus.instr_rdata_i = w;
    bus.instr_pc_i    = pc;
    bus.imm_ready_i   = rdy;
    bus.flush_i       = fl;
    bus.err_ack_i     = ack;
  endtask

  task automatic check_outs();
    chk("imm_valid", bus.imm_valid_o, m_held);
    chk("illegal", bus.illegal_o, m_err);
    chk("dec_cnt", bus.dec_cnt_o, m_cnt);
    if (m_held) begin
      chk("imm", bus.imm_o, m_imm);
      chk("imm_type", bus.imm_type_o, m_type);
      chk("pc", bus.pc_o, m_pc);
    end
    if (m_err) chk("err_pc", bus.err_pc_o, m_epc);
  endtask

  task automatic step();
    bit rdy, acc, hs;
    logic [35:0] d;
    #1;
    rdy = !m_err && (!m_held || bus.imm_ready_i);
    chk("instr_ready", bus.instr_ready_o, rdy);
    @(posedge clk);
    acc = bus.instr_valid_i && rdy && !bus.flush_i;
    hs  = m_held && bus.imm_ready_i;
    d   = ref_dec(bus.instr_rdata_i);
    if (hs) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    if (bus.flush_i) begin
      m_held = 0;
      m_err  = 0;
    end else if (acc) begin
      if (d[35]) begin
        m_err  = 1;
        m_held = 0;
        m_epc  = bus.instr_pc_i;
      end else begin
        m_held = 1;
        m_type = d[34:32];
        m_imm  = d[31:0];
        m_pc   = bus.instr_pc_i;
      end
    end else if (m_err && bus.err_ack_i) begin
      m_err = 0;
    end else if (hs) begin
      m_held = 0;
    end
    #1;
    check_outs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_held = 0;
    m_err  = 0;
    m_cnt  = 0;
    chk("rst_imm_valid", bus.imm_valid_o, 0);
    chk("rst_illegal", bus.illegal_o, 0);
    chk("rst_imm", bus.imm_o, 0);
    chk("rst_type", bus.imm_type_o, 0);
    chk("rst_pc", bus.pc_o, 0);
    chk("rst_err_pc", bus.err_pc_o, 0);
    chk("rst_cnt", bus.dec_cnt_o, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [31:0] w;
    ops = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h23,
            7'h63, 7'h37, 7'h17, 7'h6F, 7'h73};
    w = $urandom;
    case ($urandom_range(0, 5))
      0:       ;
      1:       w[6:0] = 7'h33;
      default: w[6:0] = ops[$urandom_range(0, 9)];
    endcase
    return w;
  endfunction

  logic [35:0] d0;

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    m_imm = 0; m_pc = 0; m_epc = 0; m_type = 0;
    #2;
    do_reset();

    // addi x1,x0,-1
    drive(1, 32'hFFF0_0093, 32'h100, 1, 0, 0);
    step();
    chk("addi_imm", bus.imm_o, 32'hFFFF_FFFF);
    chk("addi_type", bus.imm_type_o, 3'd1);
    chk("addi_pc", bus.pc_o, 32'h100);
    drive(0, 0, 0, 1, 0, 0);
    step();
    chk("addi_cnt", bus.dec_cnt_o, 1);

    drive(1, 32'h0000_0463, 32'h104, 1, 0, 0);
    step();
    chk("beq_imm", bus.imm_o, 32'h8);
    chk("beq_type", bus.imm_type_o, 3'd3);
    drive(1, 32'h0080_00EF, 32'h108, 1, 0, 0);
    step();
    chk("jal_imm", bus.imm_o, 32'h8);
    chk("jal_type", bus.imm_type_o, 3'd5);
    drive(1, 32'h1234_52B7, 32'h10C, 1, 0, 0);
    step();
    chk("lui_imm", bus.imm_o, 32'h1234_5000);
    chk("lui_type", bus.imm_type_o, 3'd4);
    chk("lui_valid", bus.imm_valid_o, 1);
    drive(0, 0, 0, 1, 0, 0);
    step();

    drive(1, 32'hFE11_2E23, 32'h110, 0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hFFF0_0093, 32'h114, 0, 0, 0);
      #1;
      chk("sw_stall_ready", bus.instr_ready_o, 0);
      step();
      chk("sw_imm", bus.imm_o, 32'hFFFF_FFFC);
      chk("sw_type", bus.imm_type_o, 3'd2);
    end
    drive(0, 0, 0, 1, 0, 0);
    step();

    drive(1, 32'h0000_007F, 32'h200, 1, 0, 0);
    step();
    chk("ill_flag", bus.illegal_o, 1);
    chk("ill_pc", bus.err_pc_o, 32'h200);
    drive(1, 32'hFFF0_0093, 32'h204, 1, 0, 0);
    step();
    step();
    drive(0, 0, 0, 1, 0, 1);
    step();
    chk("ack_idle", bus.illegal_o, 0);
    drive(0, 0, 0, 1, 0, 0);
    step();

    drive(1, 32'h3402_D073, 32'h300, 0, 0, 0);
    step();
    d0 = ref_dec(32'h3402_D073);
    chk("csrrwi_type", bus.imm_type_o, 3'd6);
    chk("csrrwi_imm", bus.imm_o, d0[31:0]);
    drive(0, 0, 0, 0, 1, 0);
    step();
    chk("flush_idle", bus.imm_valid_o, 0);
    drive(0, 0, 0, 1, 0, 0);
    step();

    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, 32'hFFF0_0093, 32'(i * 4), 1, 0, 0);
      step();
      if (i == 15) chk("cnt_max", bus.dec_cnt_o, 4'hF);
    end
    drive(0, 0, 0, 1, 0, 0);
    step();
    chk("cnt_wrap", bus.dec_cnt_o, 0);

    drive(1, 32'h0000_0463, 32'h400, 0, 0, 0);
    step();
    #2;
    do_reset();
    chk("post_rst_ready", bus.instr_ready_o, 1);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(),
            $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
